rob_multiport: RTL and testbench

- Parametrised reorder buffer: N-wide in-order dispatch allocation, M completion/forwarding ports, up to R-wide in-order retire.
- Sits between rename/dispatch and retire. Tracks head/tail/count explicitly, applies dispatch back-pressure and accepts a retire-stage stall.
- Replaces the fixed 16-entry, 2-in/2-out buffer. Adds full/empty handling and stall-correct retire.

---
 rtl/rob_multiport_if.sv | 60 ++++++
 rtl/rob_multiport.sv | 157 +++++++++++++++
 tb/tb_rob_multiport.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multiport_if.sv
// Dispatch, completion/forwarding and retire bundle for rob_multiport.
// The ROB uses the slave modport; the dispatch/execute/retire side uses master.
interface rob_multiport_if #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int CMPL_W = 3,
    parameter int RET_W  = 2,
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int PC_W   = 32,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic [DISP_W-1:0]        disp_valid;
    logic [DISP_W*PC_W-1:0]   disp_pc;
    logic [DISP_W*PREG_W-1:0] disp_rd;
    logic [DISP_W*PREG_W-1:0] disp_rd_old;
    logic [DISP_W-1:0]        disp_regwrite;
    logic [DISP_W-1:0]        disp_memwrite;
    logic                     disp_ready;
    logic [DISP_W*IDX_W-1:0]  disp_idx;

    logic [CMPL_W-1:0]        cmpl_valid;
    logic [CMPL_W*IDX_W-1:0]  cmpl_idx;
    logic [CMPL_W*PREG_W-1:0] cmpl_rd;
    logic [CMPL_W*DATA_W-1:0] cmpl_result;
    logic [CMPL_W*DATA_W-1:0] cmpl_mem_data;
    logic [CMPL_W-1:0]        fwd_valid;
    logic [CMPL_W*PREG_W-1:0] fwd_reg;
    logic [CMPL_W*DATA_W-1:0] fwd_val;

    logic                     ret_ready;
    logic [RET_W-1:0]         ret_valid;
    logic [RET_W*PC_W-1:0]    ret_pc;
    logic [RET_W*PREG_W-1:0]  ret_rd;
    logic [RET_W*PREG_W-1:0]  ret_rd_old;
    logic [RET_W*DATA_W-1:0]  ret_result;
    logic [RET_W*DATA_W-1:0]  ret_mem_data;
    logic [RET_W-1:0]         ret_regwrite;
    logic [RET_W-1:0]         ret_memwrite;

    modport master (
        output disp_valid, disp_pc, disp_rd, disp_rd_old, disp_regwrite, disp_memwrite,
        input  disp_ready, disp_idx,
        output cmpl_valid, cmpl_idx, cmpl_rd, cmpl_result, cmpl_mem_data,
        input  fwd_valid, fwd_reg, fwd_val,
        output ret_ready,
        input  ret_valid, ret_pc, ret_rd, ret_rd_old, ret_result, ret_mem_data,
        input  ret_regwrite, ret_memwrite
    );

    modport slave (
        input  disp_valid, disp_pc, disp_rd, disp_rd_old, disp_regwrite, disp_memwrite,
        output disp_ready, disp_idx,
        input  cmpl_valid, cmpl_idx, cmpl_rd, cmpl_result, cmpl_mem_data,
        output fwd_valid, fwd_reg, fwd_val,
        input  ret_ready,
        output ret_valid, ret_pc, ret_rd, ret_rd_old, ret_result, ret_mem_data,
        output ret_regwrite, ret_memwrite
    );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer: DISP_W-wide in-order allocate, CMPL_W completion/forward ports,
// up to RET_W-wide in-order retire with stall. Optional flush input under ROB_FLUSH_EN.
module rob_multiport #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int CMPL_W = 3,
    parameter int RET_W  = 2,
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int PC_W   = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
`ifdef ROB_FLUSH_EN
    input  logic           flush,
`endif
    rob_multiport_if.slave rob,
    output logic [IDX_W:0] count,
    output logic           full,
    output logic           empty
);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              valid_q    [DEPTH];
    logic              complete_q [DEPTH];
    logic [PC_W-1:0]   pc_q       [DEPTH];
    logic [PREG_W-1:0] rd_q       [DEPTH];
    logic [PREG_W-1:0] rd_old_q   [DEPTH];
    logic              regwrite_q [DEPTH];
    logic              memwrite_q [DEPTH];
    logic [DATA_W-1:0] result_q   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [CNT_W-1:0]  n_disp, n_ret, n_acc, n_rm;
    logic [IDX_W-1:0]  ret_idx [RET_W];
    logic              run;
    logic              clear;

`ifdef ROB_FLUSH_EN
    assign clear = reset | flush;
`else
    assign clear = reset;
`endif

    assign count          = count_q;
    assign full           = (count_q == CNT_W'(DEPTH));
    assign empty          = (count_q == '0);
    assign rob.disp_ready = (count_q <= CNT_W'(DEPTH - DISP_W));
    assign n_acc          = rob.disp_ready ? n_disp : '0;
    assign n_rm           = rob.ret_ready ? n_ret : '0;

    // Valid lanes are packed onto consecutive slots starting at tail.
    always_comb begin
        n_disp       = '0;
        rob.disp_idx = '0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            rob.disp_idx[i*IDX_W +: IDX_W] = tail_q + n_disp[IDX_W-1:0];
            if (rob.disp_valid[i]) n_disp = n_disp + CNT_W'(1);
        end
    end

    always_comb begin
        n_ret = '0;
        run   = 1'b1;
        for (int unsigned j = 0; j < RET_W; j++) begin
            ret_idx[j] = head_q + IDX_W'(j);
            if (run && (CNT_W'(j) < count_q) && valid_q[ret_idx[j]] && complete_q[ret_idx[j]])
                n_ret = n_ret + CNT_W'(1);
            else
                run = 1'b0;
        end
    end

    always_comb begin
        rob.fwd_valid = rob.cmpl_valid;
        rob.fwd_reg   = '0;
        rob.fwd_val   = '0;
        for (int unsigned c = 0; c < CMPL_W; c++) begin
            if (rob.cmpl_valid[c]) begin
                rob.fwd_reg[c*PREG_W +: PREG_W] = rob.cmpl_rd[c*PREG_W +: PREG_W];
                rob.fwd_val[c*DATA_W +: DATA_W] = rob.cmpl_result[c*DATA_W +: DATA_W];
            end
        end
    end

    // Statement order matters: later completion ports overwrite earlier ones, and the
    // retire clear overrides a redundant completion to an entry leaving this cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
                valid_q[d]    <= 1'b0;
                complete_q[d] <= 1'b0;
            end
        end else begin
            for (int unsigned c = 0; c < CMPL_W; c++) begin
                if (rob.cmpl_valid[c] && valid_q[rob.cmpl_idx[c*IDX_W +: IDX_W]]) begin
                    complete_q[rob.cmpl_idx[c*IDX_W +: IDX_W]] <= 1'b1;
                    result_q[rob.cmpl_idx[c*IDX_W +: IDX_W]]   <= rob.cmpl_result[c*DATA_W +: DATA_W];
                    mem_data_q[rob.cmpl_idx[c*IDX_W +: IDX_W]] <= rob.cmpl_mem_data[c*DATA_W +: DATA_W];
                end
            end
            for (int unsigned j = 0; j < RET_W; j++) begin
                if (CNT_W'(j) < n_rm) begin
                    valid_q[ret_idx[j]]    <= 1'b0;
                    complete_q[ret_idx[j]] <= 1'b0;
                end
            end
            if (rob.disp_ready) begin
                for (int unsigned i = 0; i < DISP_W; i++) begin
                    if (rob.disp_valid[i]) begin
                        valid_q[rob.disp_idx[i*IDX_W +: IDX_W]]    <= 1'b1;
                        complete_q[rob.disp_idx[i*IDX_W +: IDX_W]] <= 1'b0;
                        pc_q[rob.disp_idx[i*IDX_W +: IDX_W]]       <= rob.disp_pc[i*PC_W +: PC_W];
                        rd_q[rob.disp_idx[i*IDX_W +: IDX_W]]       <= rob.disp_rd[i*PREG_W +: PREG_W];
                        rd_old_q[rob.disp_idx[i*IDX_W +: IDX_W]]   <= rob.disp_rd_old[i*PREG_W +: PREG_W];
                        regwrite_q[rob.disp_idx[i*IDX_W +: IDX_W]] <= rob.disp_regwrite[i];
                        memwrite_q[rob.disp_idx[i*IDX_W +: IDX_W]] <= rob.disp_memwrite[i];
                    end
                end
            end
            head_q  <= head_q + n_rm[IDX_W-1:0];
            tail_q  <= tail_q + n_acc[IDX_W-1:0];
            count_q <= count_q + n_acc - n_rm;
        end
    end

    always_ff @(posedge clk) begin
        rob.ret_valid    <= '0;
        rob.ret_pc       <= '0;
        rob.ret_rd       <= '0;
        rob.ret_rd_old   <= '0;
        rob.ret_result   <= '0;
        rob.ret_mem_data <= '0;
        rob.ret_regwrite <= '0;
        rob.ret_memwrite <= '0;
        if (!clear) begin
            for (int unsigned j = 0; j < RET_W; j++) begin
                if (CNT_W'(j) < n_rm) begin
                    rob.ret_valid[j]                     <= 1'b1;
                    rob.ret_pc[j*PC_W +: PC_W]           <= pc_q[ret_idx[j]];
                    rob.ret_rd[j*PREG_W +: PREG_W]       <= rd_q[ret_idx[j]];
                    rob.ret_rd_old[j*PREG_W +: PREG_W]   <= rd_old_q[ret_idx[j]];
                    rob.ret_result[j*DATA_W +: DATA_W]   <= result_q[ret_idx[j]];
                    rob.ret_mem_data[j*DATA_W +: DATA_W] <= mem_data_q[ret_idx[j]];
                    rob.ret_regwrite[j]                  <= regwrite_q[ret_idx[j]];
                    rob.ret_memwrite[j]                  <= memwrite_q[ret_idx[j]];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_multiport.sv
// Randomized self-checking bench for rob_multiport against a program-order queue model.
module tb_rob_multiport;
    localparam int DEPTH  = 16;
    localparam int DISP_W = 2;
    localparam int CMPL_W = 3;
    localparam int RET_W  = 2;
    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int PC_W   = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           reset;
    logic           flush = 1'b0;
    logic [IDX_W:0] count;
    logic           full, empty;

    always #5 clk = ~clk;

    rob_multiport_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMPL_W(CMPL_W), .RET_W(RET_W),
                       .DATA_W(DATA_W), .PREG_W(PREG_W), .PC_W(PC_W)) bus ();

    rob_multiport #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMPL_W(CMPL_W), .RET_W(RET_W),
                    .DATA_W(DATA_W), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef ROB_FLUSH_EN
        .flush (flush),
`endif
        .rob   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    typedef struct {
        int unsigned       idx;
        logic [PC_W-1:0]   pc;
        logic [PREG_W-1:0] rd, rd_old;
        logic              rw, mw, done;
        logic [DATA_W-1:0] res, mem;
    } ent_t;

    ent_t        q[$];
    ent_t        exp_ret[$];
    int unsigned m_tail;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid    = '0;
        bus.disp_pc       = '0;
        bus.disp_rd       = '0;
        bus.disp_rd_old   = '0;
        bus.disp_regwrite = '0;
        bus.disp_memwrite = '0;
        bus.cmpl_valid    = '0;
        bus.cmpl_idx      = '0;
        bus.cmpl_rd       = '0;
        bus.cmpl_result   = '0;
        bus.cmpl_mem_data = '0;
        bus.ret_ready     = 1'b1;
        flush             = 1'b0;
    endtask

    task automatic disp_lane(input int unsigned i, input logic [PC_W-1:0] pc);
        bus.disp_valid[i]                 = 1'b1;
        bus.disp_pc[i*PC_W +: PC_W]       = pc;
        bus.disp_rd[i*PREG_W +: PREG_W]   = PREG_W'($urandom);
        bus.disp_rd_old[i*PREG_W +: PREG_W] = PREG_W'($urandom);
        bus.disp_regwrite[i]              = 1'($urandom);
        bus.disp_memwrite[i]              = 1'($urandom);
    endtask

    task automatic cmpl_port(input int unsigned c, input int unsigned idx, input logic [DATA_W-1:0] res);
        bus.cmpl_valid[c]                   = 1'b1;
        bus.cmpl_idx[c*IDX_W +: IDX_W]      = IDX_W'(idx);
        bus.cmpl_rd[c*PREG_W +: PREG_W]     = PREG_W'($urandom);
        bus.cmpl_result[c*DATA_W +: DATA_W] = res;
        bus.cmpl_mem_data[c*DATA_W +: DATA_W] = $urandom;
    endtask

    // One clock: check combinational outputs, advance the model, check registered retire lanes.
    task automatic cycle();
        int unsigned below, k;
        bit          rdy;
        ent_t        e;
        #1;
        rdy = (DEPTH - q.size()) >= DISP_W;
        check("disp_ready", bus.disp_ready, rdy);
        check("count", count, q.size());
        check("full", full, q.size() == DEPTH);
        check("empty", empty, q.size() == 0);
        below = 0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            check("disp_idx", bus.disp_idx[i*IDX_W +: IDX_W], (m_tail + below) % DEPTH);
            if (bus.disp_valid[i]) below++;
        end
        for (int unsigned c = 0; c < CMPL_W; c++) begin
            check("fwd_valid", bus.fwd_valid[c], bus.cmpl_valid[c]);
            check("fwd_reg", bus.fwd_reg[c*PREG_W +: PREG_W],
                  bus.cmpl_valid[c] ? bus.cmpl_rd[c*PREG_W +: PREG_W] : '0);
            check("fwd_val", bus.fwd_val[c*DATA_W +: DATA_W],
                  bus.cmpl_valid[c] ? bus.cmpl_result[c*DATA_W +: DATA_W] : '0);
        end

        exp_ret.delete();
        if (flush) begin
            q.delete();
            m_tail = 0;
        end else begin
            k = 0;
            while (k < RET_W && k < q.size() && q[k].done) k++;
            if (bus.ret_ready)
                for (int unsigned j = 0; j < k; j++) exp_ret.push_back(q.pop_front());
            for (int unsigned c = 0; c < CMPL_W; c++) begin
                if (bus.cmpl_valid[c]) begin
                    foreach (q[n]) begin
                        if (q[n].idx == bus.cmpl_idx[c*IDX_W +: IDX_W]) begin
                            q[n].done = 1'b1;
                            q[n].res  = bus.cmpl_result[c*DATA_W +: DATA_W];
                            q[n].mem  = bus.cmpl_mem_data[c*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            if (rdy) begin
                for (int unsigned i = 0; i < DISP_W; i++) begin
                    if (bus.disp_valid[i]) begin
                        e.idx    = m_tail;
                        e.pc     = bus.disp_pc[i*PC_W +: PC_W];
                        e.rd     = bus.disp_rd[i*PREG_W +: PREG_W];
                        e.rd_old = bus.disp_rd_old[i*PREG_W +: PREG_W];
                        e.rw     = bus.disp_regwrite[i];
                        e.mw     = bus.disp_memwrite[i];
                        e.done   = 1'b0;
                        e.res    = '0;
                        e.mem    = '0;
                        q.push_back(e);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        for (int unsigned j = 0; j < RET_W; j++) begin
            if (j < exp_ret.size())
                check("ret_lane",
                      {bus.ret_valid[j], bus.ret_pc[j*PC_W +: PC_W], bus.ret_rd[j*PREG_W +: PREG_W],
                       bus.ret_rd_old[j*PREG_W +: PREG_W], bus.ret_result[j*DATA_W +: DATA_W],
                       bus.ret_mem_data[j*DATA_W +: DATA_W], bus.ret_regwrite[j], bus.ret_memwrite[j]},
                      {1'b1, exp_ret[j].pc, exp_ret[j].rd, exp_ret[j].rd_old, exp_ret[j].res,
                       exp_ret[j].mem, exp_ret[j].rw, exp_ret[j].mw});
            else
                check("ret_idle_lane",
                      {bus.ret_valid[j], bus.ret_pc[j*PC_W +: PC_W], bus.ret_rd[j*PREG_W +: PREG_W],
                       bus.ret_rd_old[j*PREG_W +: PREG_W], bus.ret_result[j*DATA_W +: DATA_W],
                       bus.ret_mem_data[j*DATA_W +: DATA_W], bus.ret_regwrite[j], bus.ret_memwrite[j]},
                      '0);
        end
        @(negedge clk);
    endtask

    task automatic random_inputs();
        bit          rdy;
        int unsigned idx;
        bit          in_q;
        idle();
        rdy = (DEPTH - q.size()) >= DISP_W;
        for (int unsigned i = 0; i < DISP_W; i++)
            if ($urandom_range(0, 1) == 1) disp_lane(i, $urandom);
        bus.ret_ready = ($urandom_range(0, 3) != 0);
        for (int unsigned c = 0; c < CMPL_W; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                idx  = $urandom_range(0, DEPTH - 1);
                in_q = 1'b0;
                foreach (q[n]) if (q[n].idx == idx) in_q = 1'b1;
                // a completion aimed at a slot being allocated this cycle is undefined
                if (in_q || !rdy || bus.disp_valid == '0) cmpl_port(c, idx, $urandom);
            end else if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                cmpl_port(c, q[$urandom_range(0, q.size() - 1)].idx, $urandom);
            end
        end
    endtask

    initial begin
        idle();
        reset  = 1'b1;
        m_tail = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_disp_ready", bus.disp_ready, 1'b1);
        check("rst_ret_valid", bus.ret_valid, '0);
        @(negedge clk);
        reset = 1'b0;

        // Two-lane dispatch, out-of-order completion, paired retire.
        idle(); disp_lane(0, 32'h100); disp_lane(1, 32'h104); cycle();
        idle(); cmpl_port(0, 1, 32'h11); cycle();
        idle(); cmpl_port(1, 0, 32'h22); cycle();
        idle(); cycle();
        check("pair_ret_valid", bus.ret_valid, 2'b11);
        check("pair_ret_pc0", bus.ret_pc[PC_W-1:0], 32'h100);
        check("pair_ret_pc1", bus.ret_pc[2*PC_W-1:PC_W], 32'h104);

        // Same index on ports 0 and 2: port 2 wins.
        idle(); disp_lane(0, 32'h200); cycle();
        idle(); cmpl_port(0, 2, 32'hAA); cmpl_port(2, 2, 32'hBB); cycle();
        idle(); cycle();
        check("same_idx_result", bus.ret_result[DATA_W-1:0], 32'hBB);

        // Fill to full with retire stalled; extra dispatch ignored; head wraps during drain.
        for (int unsigned n = 0; n < 9; n++) begin
            idle(); bus.ret_ready = 1'b0;
            disp_lane(0, 32'h1000 + 8 * n); disp_lane(1, 32'h1004 + 8 * n); cycle();
        end
        check("fill_full", full, 1'b1);
        check("fill_disp_ready", bus.disp_ready, 1'b0);
        for (int unsigned n = 0; n < DEPTH; n += CMPL_W) begin
            idle(); bus.ret_ready = 1'b0;
            for (int unsigned c = 0; c < CMPL_W; c++)
                if (n + c < DEPTH) cmpl_port(c, (3 + n + c) % DEPTH, $urandom);
            cycle();
        end
        for (int unsigned n = 0; n < 3; n++) begin
            idle(); bus.ret_ready = 1'b0; cycle();
        end
        check("stall_count", count, DEPTH);
        for (int unsigned n = 0; n < 9; n++) begin
            idle(); cycle();
        end
        check("drain_empty", empty, 1'b1);

        for (int unsigned n = 0; n < 3000; n++) begin
            random_inputs();
            cycle();
        end

`ifdef ROB_FLUSH_EN
        idle();
        for (int unsigned n = 0; n < 12; n++) cycle();
        while (q.size() < 5) begin
            idle(); bus.ret_ready = 1'b0; disp_lane(0, $urandom); cycle();
        end
        idle(); flush = 1'b1; disp_lane(0, 32'h300); cmpl_port(0, q[0].idx, 32'h1); cycle();
        check("flush_count", count, 0);
        check("flush_empty", empty, 1'b1);
        idle(); cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
